alu_result_display: RTL and testbench
=====================================

Name: alu_result_display

Overview:
- Downstream consumer of the 3-bit arithmetic unit: latches its 5-bit sign-magnitude result and its DZF/ZF/SF flags on a valid strobe.
- Drives a 3-digit multiplexed 7-segment display plus two status LEDs.
- Digit positions are sign, tens and units. A divide-by-zero result shows "Err".
- Sits between the combinational ALU and the board I/O pins.

Parameters:
- SCAN_DIV, 50000, clocks each digit stays enabled before the scan advances (minimum 2).
- DIV_W, $clog2(SCAN_DIV), width of the scan prescaler counter.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  one-cycle strobe; capture i_result and flags this edge.
- i_clear  input  1  synchronous return to blank display.
- i_result  input  5  ALU result; bit4 = sign (1 = negative), bits3:0 = magnitude.
- i_dzf  input  1  divide-by-zero flag.
- i_zf  input  1  zero flag.
- i_sf  input  1  sign flag.
- o_seg  output  7  registered segment pattern {g,f,e,d,c,b,a}, active-high.
- o_an  output  3  registered digit enables, one-hot active-low; an[0] = units, an[2] = sign.
- o_zf_led  output  1  registered copy of the latched ZF.
- o_sf_led  output  1  registered copy of the latched SF.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_seg=7'h00, o_an=3'b111, o_zf_led=0, o_sf_led=0.
  - State=IDLE, prescaler=0, digit index=0, latched data=0.
- FSM states: IDLE (all digits blank), SHOW (numeric), ERR (shows "Err").
  - Any state, i_clear=1 -> IDLE; i_clear has priority over a simultaneous i_valid.
  - Any state, i_valid=1 and i_dzf=1 -> ERR.
  - Any state, i_valid=1 and i_dzf=0 -> SHOW.
  - Otherwise hold state.
  - A new i_valid always overwrites the latched data, including in ERR.
- Capture: result, ZF and SF are registered on the edge where i_valid=1.
  - LEDs update on that same edge.
  - In IDLE the LEDs read 0.
- Decode (SHOW), with mag = result[3:0] in 0..15:
  - units = mag mod 10; tens = 1 if mag >= 10, else blank (leading-zero blanking).
  - Sign digit = '-' if result[4]=1 and mag != 0, else blank; negative zero shows as "  0".
- ERR digits: sign position 'E', tens 'r', units 'r'.
- Segment codes:
  - Digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - '-'=40, blank=00, 'E'=79, 'r'=50.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap the digit index advances 0->1->2->0; the index never holds 3.
  - The prescaler runs in every state and is unaffected by i_valid and i_clear.
- Output timing:
  - o_an and o_seg are registered from the digit index and decoded data.
  - A capture at edge N is visible on o_seg from edge N+1 for the active digit.
  - Exactly one o_an bit is low at any time after the first clock following reset.
- Reset mid-scan: all outputs return to reset values immediately, asynchronously.
- Inputs are sampled only when i_valid=1; i_result/flag changes at other times are ignored.

Optional Feature:
- Macro: ALU_DISP_BLINK_ERR_EN.
- Defined:
  - In ERR, all digits blank during alternate half-periods of a blink counter.
  - The blink counter toggles every 8 completed scan rounds (3*SCAN_DIV clocks each).
  - Phase starts visible on entry to ERR.
  - o_an keeps scanning; only o_seg is forced to 00.
- Undefined: ERR displays steadily and no blink counter is synthesized.

Test Plan (SCAN_DIV=4):
- Reset then idle 40 clocks -> o_seg=00 throughout; o_an cycles 110,101,011, changing every 4 clocks; LEDs 0.
- i_valid with i_result=5'b10110 (-6), zf=0, sf=1 -> units 7D, tens 00, sign 40; o_sf_led=1 from the next edge.
- i_valid with i_result=5'b01001 (+9), then i_valid with 5'b10000 -> first shows "  9" (6F); then "  0" (units 3F, sign 00).
- i_valid with i_result=5'b01100 (12) -> units 5B, tens 06, sign 00.
- i_valid with i_dzf=1 -> sign 79, tens 50, units 50; then i_valid and i_clear in the same cycle -> IDLE, all 00.
- Assert i_rst_n=0 mid-digit while in SHOW -> o_an=111 and o_seg=00 without waiting for a clock edge; scan restarts at an[0] after release.

Source files
------------

// File: rtl/alu_result_display.sv
// Latches ALU result/flags on i_valid and scans them onto a 3-digit 7-segment display.
// Optional macro ALU_DISP_BLINK_ERR_EN: blink the "Err" message every 8 scan rounds.
module alu_result_display #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIV_W    = $clog2(SCAN_DIV)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_clear,
  input  logic [4:0] i_result,
  input  logic       i_dzf,
  input  logic       i_zf,
  input  logic       i_sf,
  output logic [6:0] o_seg,
  output logic [2:0] o_an,
  output logic       o_zf_led,
  output logic       o_sf_led
);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_ERR} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [4:0]       r_result;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;
  logic             r_zf_led;
  logic             r_sf_led;

  logic             w_div_wrap;
  logic [3:0]       w_mag;
  logic             w_ge10;
  logic [3:0]       w_units;
  logic [6:0]       w_seg;
  logic [2:0]       w_an;

`ifdef ALU_DISP_BLINK_ERR_EN
  logic [2:0]       r_round;
  logic             r_blank;
  logic             w_round_wrap;
  assign w_round_wrap = w_div_wrap && (r_idx == 2'd2);
`endif

  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    case (d)
      4'd0:    f_seg7 = 7'h3F;
      4'd1:    f_seg7 = 7'h06;
      4'd2:    f_seg7 = 7'h5B;
      4'd3:    f_seg7 = 7'h4F;
      4'd4:    f_seg7 = 7'h66;
      4'd5:    f_seg7 = 7'h6D;
      4'd6:    f_seg7 = 7'h7D;
      4'd7:    f_seg7 = 7'h07;
      4'd8:    f_seg7 = 7'h7F;
      4'd9:    f_seg7 = 7'h6F;
      default: f_seg7 = 7'h00;
    endcase
  endfunction

  assign w_div_wrap = (r_div == DIV_MAX);
  assign w_mag      = r_result[3:0];
  assign w_ge10     = (w_mag >= 4'd10);
  assign w_units    = w_ge10 ? (w_mag - 4'd10) : w_mag;

  // Segment pattern and anode enable for the digit currently selected by the scan
  always_comb begin
    w_seg = 7'h00;
    w_an  = 3'b110;
    case (r_idx)
      2'd1:    w_an = 3'b101;
      2'd2:    w_an = 3'b011;
      default: w_an = 3'b110;
    endcase
    case (r_state)
      S_SHOW: begin
        case (r_idx)
          2'd0:    w_seg = f_seg7(w_units);
          2'd1:    w_seg = w_ge10 ? 7'h06 : 7'h00;
          2'd2:    w_seg = (r_result[4] && (w_mag != 4'd0)) ? 7'h40 : 7'h00;
          default: w_seg = 7'h00;
        endcase
      end
      S_ERR: begin
        w_seg = (r_idx == 2'd2) ? 7'h79 : 7'h50;
`ifdef ALU_DISP_BLINK_ERR_EN
        if (r_blank) w_seg = 7'h00;
`endif
      end
      default: w_seg = 7'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_idx    <= 2'd0;
      r_result <= 5'd0;
      r_seg    <= 7'h00;
      r_an     <= 3'b111;
      r_zf_led <= 1'b0;
      r_sf_led <= 1'b0;
`ifdef ALU_DISP_BLINK_ERR_EN
      r_round  <= 3'd0;
      r_blank  <= 1'b0;
`endif
    end else begin
      r_div <= w_div_wrap ? '0 : (r_div + DIV_W'(1));
      if (w_div_wrap) r_idx <= (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);
      r_seg <= w_seg;
      r_an  <= w_an;
      // Clear wins over a coincident capture
      if (i_clear) begin
        r_state  <= S_IDLE;
        r_zf_led <= 1'b0;
        r_sf_led <= 1'b0;
      end else if (i_valid) begin
        r_result <= i_result;
        r_zf_led <= i_zf;
        r_sf_led <= i_sf;
        r_state  <= i_dzf ? S_ERR : S_SHOW;
      end
`ifdef ALU_DISP_BLINK_ERR_EN
      if (!i_clear && i_valid && i_dzf) begin
        r_round <= 3'd0;
        r_blank <= 1'b0;
      end else if ((r_state == S_ERR) && w_round_wrap) begin
        r_round <= r_round + 3'd1;
        if (r_round == 3'd7) r_blank <= ~r_blank;
      end
`endif
    end
  end

  assign o_seg    = r_seg;
  assign o_an     = r_an;
  assign o_zf_led = r_zf_led;
  assign o_sf_led = r_sf_led;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed self-checking bench for alu_result_display with SCAN_DIV=4.
module tb_alu_result_display;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_clear = 1'b0;
  logic [4:0] i_result = 5'd0;
  logic       i_dzf = 1'b0;
  logic       i_zf = 1'b0;
  logic       i_sf = 1'b0;
  logic [6:0] o_seg;
  logic [2:0] o_an;
  logic       o_zf_led;
  logic       o_sf_led;

  int n_total = 0;
  int n_bad   = 0;

  logic [2:0] an_of [3] = '{3'b110, 3'b101, 3'b011};

  alu_result_display #(.SCAN_DIV(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_clear(i_clear),
    .i_result(i_result), .i_dzf(i_dzf), .i_zf(i_zf), .i_sf(i_sf),
    .o_seg(o_seg), .o_an(o_an), .o_zf_led(o_zf_led), .o_sf_led(o_sf_led)
  );

  always #5 i_clk = ~i_clk;

  // Bounded wait (on falling edges) until the given digit is enabled
  task automatic wait_an(input logic [2:0] an, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_an === an) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  // One-cycle strobe driven from a falling edge; returns at the falling edge after capture
  task automatic pulse(input logic [4:0] res, input logic dzf, input logic zf,
                       input logic sf, input logic clr);
    i_result = res; i_dzf = dzf; i_zf = zf; i_sf = sf;
    i_valid = 1'b1; i_clear = clr;
    @(negedge i_clk);
    i_valid = 1'b0; i_clear = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    n_total++;
    if (o_seg !== 7'h00 || o_an !== 3'b111) begin
      n_bad++; $display("FAIL reset_out seg=%h an=%b want seg=00 an=111", o_seg, o_an);
    end
    n_total++;
    if (o_zf_led !== 1'b0 || o_sf_led !== 1'b0) begin
      n_bad++; $display("FAIL reset_led zf=%b sf=%b want 0 0", o_zf_led, o_sf_led);
    end
    ok = 1'b1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [2:0] exp_an;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      exp_an = an_of[((k - 1) / 4) % 3];
      n_total++;
      if (o_an !== exp_an || o_seg !== 7'h00) begin
        n_bad++;
        $display("FAIL idle_scan k=%0d an=%b seg=%h want an=%b seg=00", k, o_an, o_seg, exp_an);
      end
    end
    n_total++;
    if (o_zf_led !== 1'b0 || o_sf_led !== 1'b0) begin
      n_bad++; $display("FAIL idle_led zf=%b sf=%b want 0 0", o_zf_led, o_sf_led);
    end
  endtask

  task automatic test_negative();
    logic [6:0] exp [3] = '{7'h7D, 7'h00, 7'h40};
    bit ok;
    pulse(5'b10110, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (o_sf_led !== 1'b1 || o_zf_led !== 1'b0) begin
      n_bad++; $display("FAIL neg_led sf=%b zf=%b want sf=1 zf=0", o_sf_led, o_zf_led);
    end
    @(negedge i_clk);
    for (int d = 0; d < 3; d++) begin
      wait_an(an_of[d], ok);
      n_total++;
      if (!ok) begin
        n_bad++; $display("FAIL neg_timeout digit=%0d an=%b", d, o_an);
      end else if (o_seg !== exp[d]) begin
        n_bad++; $display("FAIL neg_digit%0d seg=%h want %h", d, o_seg, exp[d]);
      end
    end
  endtask

  task automatic test_sign_zero();
    logic [6:0] exp9 [3] = '{7'h6F, 7'h00, 7'h00};
    logic [6:0] exp0 [3] = '{7'h3F, 7'h00, 7'h00};
    bit ok;
    pulse(5'b01001, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    for (int d = 0; d < 3; d++) begin
      wait_an(an_of[d], ok);
      n_total++;
      if (!ok) begin
        n_bad++; $display("FAIL pos9_timeout digit=%0d an=%b", d, o_an);
      end else if (o_seg !== exp9[d]) begin
        n_bad++; $display("FAIL pos9_digit%0d seg=%h want %h", d, o_seg, exp9[d]);
      end
    end
    pulse(5'b10000, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (o_zf_led !== 1'b1 || o_sf_led !== 1'b0) begin
      n_bad++; $display("FAIL negzero_led zf=%b sf=%b want zf=1 sf=0", o_zf_led, o_sf_led);
    end
    @(negedge i_clk);
    for (int d = 0; d < 3; d++) begin
      wait_an(an_of[d], ok);
      n_total++;
      if (!ok) begin
        n_bad++; $display("FAIL negzero_timeout digit=%0d an=%b", d, o_an);
      end else if (o_seg !== exp0[d]) begin
        n_bad++; $display("FAIL negzero_digit%0d seg=%h want %h", d, o_seg, exp0[d]);
      end
    end
  endtask

  task automatic test_two_digit();
    logic [6:0] exp [3] = '{7'h5B, 7'h06, 7'h00};
    bit ok;
    pulse(5'b01100, 1'b0, 1'b0, 1'b0, 1'b0);
    // Input changes without a strobe must be ignored
    i_result = 5'b11111; i_zf = 1'b1; i_sf = 1'b1; i_dzf = 1'b1;
    @(negedge i_clk);
    for (int d = 0; d < 3; d++) begin
      wait_an(an_of[d], ok);
      n_total++;
      if (!ok) begin
        n_bad++; $display("FAIL twelve_timeout digit=%0d an=%b", d, o_an);
      end else if (o_seg !== exp[d]) begin
        n_bad++; $display("FAIL twelve_digit%0d seg=%h want %h", d, o_seg, exp[d]);
      end
    end
    n_total++;
    if (o_zf_led !== 1'b0 || o_sf_led !== 1'b0) begin
      n_bad++; $display("FAIL twelve_led zf=%b sf=%b want 0 0", o_zf_led, o_sf_led);
    end
  endtask

  task automatic test_err_clear();
    logic [6:0] exp [3] = '{7'h50, 7'h50, 7'h79};
    bit ok;
    pulse(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    for (int d = 0; d < 3; d++) begin
      wait_an(an_of[d], ok);
      n_total++;
      if (!ok) begin
        n_bad++; $display("FAIL err_timeout digit=%0d an=%b", d, o_an);
      end else if (o_seg !== exp[d]) begin
        n_bad++; $display("FAIL err_digit%0d seg=%h want %h", d, o_seg, exp[d]);
      end
    end
    pulse(5'b01001, 1'b0, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (o_zf_led !== 1'b0 || o_sf_led !== 1'b0) begin
      n_bad++; $display("FAIL clear_led zf=%b sf=%b want 0 0", o_zf_led, o_sf_led);
    end
    @(negedge i_clk);
    for (int d = 0; d < 3; d++) begin
      wait_an(an_of[d], ok);
      n_total++;
      if (!ok) begin
        n_bad++; $display("FAIL clear_timeout digit=%0d an=%b", d, o_an);
      end else if (o_seg !== 7'h00) begin
        n_bad++; $display("FAIL clear_digit%0d seg=%h want 00", d, o_seg);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    pulse(5'b00111, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    wait_an(3'b110, ok);
    @(posedge i_clk);
    #2;
    n_total++;
    if (!ok || o_seg !== 7'h07) begin
      n_bad++; $display("FAIL pre_reset ok=%0d seg=%h want 07", ok, o_seg);
    end
    i_rst_n = 1'b0;
    #1;
    n_total++;
    if (o_an !== 3'b111 || o_seg !== 7'h00) begin
      n_bad++; $display("FAIL async_reset an=%b seg=%h want an=111 seg=00", o_an, o_seg);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_total++;
    if (o_an !== 3'b110 || o_seg !== 7'h00) begin
      n_bad++; $display("FAIL post_reset an=%b seg=%h want an=110 seg=00", o_an, o_seg);
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_negative();
    test_sign_zero();
    test_two_digit();
    test_err_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
